// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ producers share one sync FIFO write port.
// A grant is held for a whole packet (until last) or until the holder stalls for TIMEOUT cycles.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          locked
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           state_r;
    logic [IDW-1:0]   grant_id_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [7:0]       stall_r;

    logic [IDW-1:0]   sel_s;
    logic [IDW-1:0]   next_id_s;
    logic             gvalid_s;
    logic             glast_s;
    logic             beat_s;

    assign grant_id = grant_id_r;
    assign locked   = (state_r == ST_LOCK);

    // Round-robin pick: scan downward in offset so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx   = 0;
        sel_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_r) + k) % NUM_REQ;
            if (req_valid[IDW'(idx)]) begin
                sel_s = IDW'(idx);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Signals of the current grant holder and the pointer that follows it.
    always_comb begin
        gvalid_s  = req_valid[grant_id_r];
        glast_s   = req_last[grant_id_r];
        next_id_s = (grant_id_r == IDW'(NUM_REQ - 1)) ? '0 : grant_id_r + IDW'(1);
    end

    // Handshake outputs; reset forces them low even if the state register is stale.
    always_comb begin
        req_ready  = '0;
        fifo_w_en  = 1'b0;
        beat_s     = 1'b0;
        fifo_wdata = req_data[int'(grant_id_r) * DATA_WIDTH +: DATA_WIDTH];
        if (rst_n && (state_r == ST_LOCK)) begin
            req_ready[grant_id_r] = !fifo_full;
            beat_s                = gvalid_s && !fifo_full;
            fifo_w_en             = beat_s;
        end else begin
            req_ready = '0;
            fifo_w_en = 1'b0;
        end
    end

    // Grant FSM with stall timeout; full-blocked cycles neither transfer nor count as stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
            stall_r    <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stall_r <= 8'd0;
                    if (|req_valid) begin
                        grant_id_r <= sel_s;
                        state_r    <= ST_LOCK;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (beat_s) begin
                        stall_r <= 8'd0;
                        if (glast_s) begin
                            state_r  <= ST_IDLE;
                            rr_ptr_r <= next_id_s;
                        end else begin
                            state_r  <= ST_LOCK;
                        end
                    end else if (!gvalid_s) begin
                        if (stall_r == STALL_LAST) begin
                            stall_r  <= 8'd0;
                            state_r  <= ST_IDLE;
                            rr_ptr_r <= next_id_s;
                        end else begin
                            stall_r  <= stall_r + 8'd1;
                        end
                    end else begin
                        stall_r <= stall_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    stall_r <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: hand-computed grants, beats, full blocking, timeout and reset.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_w_en;
    logic [DW-1:0]     fifo_wdata;
    logic [1:0]        grant_id;
    logic              locked;

    int n_vec = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
        .fifo_wdata(fifo_wdata), .grant_id(grant_id), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DW-1:0] val);
        req_data[idx*DW +: DW] = val;
    endtask

    task automatic chk_beat(input string tag, input int id, input logic [DW-1:0] data);
        logic [NR-1:0] rdy;
        rdy = '0;
        rdy[id] = 1'b1;
        check({tag, "_locked"}, locked, 1);
        check({tag, "_grant"}, grant_id, id);
        check({tag, "_ready"}, req_ready, rdy);
        check({tag, "_wen"}, fifo_w_en, 1);
        check({tag, "_wdata"}, fifo_wdata, data);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_wen"}, fifo_w_en, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        req_last  = 4'b0000;
        req_data  = '0;
        fifo_full = 1'b0;
        #1;
        check("rst_ready_comb", req_ready, 0);
        check("rst_wen_comb", fifo_w_en, 0);
        next_cycle();
        next_cycle();
        check("rst_locked", locked, 0);
        check("rst_grant", grant_id, 0);

        // Two 2-word packets from producers 1 and 3
        set_data(1, 8'h11);
        set_data(3, 8'h31);
        rst_n = 1'b1;
        #1;
        chk_idle("p13_arb");
        next_cycle();
        chk_beat("p1_w0", 1, 8'h11);
        next_cycle();
        set_data(1, 8'h12);
        req_last = 4'b0010;
        #1;
        chk_beat("p1_w1", 1, 8'h12);
        next_cycle();
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        #1;
        chk_idle("p13_gap");
        next_cycle();
        chk_beat("p3_w0", 3, 8'h31);
        next_cycle();
        set_data(3, 8'h32);
        req_last = 4'b1000;
        #1;
        chk_beat("p3_w1", 3, 8'h32);
        next_cycle();

        // All producers valid with 1-word packets: 0,1,2,3,0
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int i = 0; i < NR; i++) set_data(i, 8'(8'hA0 + i));
        #1;
        for (int k = 0; k < 5; k++) begin
            chk_idle("rr_arb");
            next_cycle();
            chk_beat("rr_beat", k % 4, 8'(8'hA0 + (k % 4)));
            next_cycle();
        end

        // Producer 2 held off by fifo_full mid-packet (rr_ptr is 1 here)
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        set_data(2, 8'hC0);
        #1;
        chk_idle("full_arb");
        next_cycle();
        chk_beat("full_w0", 2, 8'hC0);
        next_cycle();
        set_data(2, 8'hC1);
        fifo_full = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("full5_wen", fifo_w_en, 0);
            check("full5_ready", req_ready, 0);
            check("full5_locked", locked, 1);
            next_cycle();
        end
        fifo_full = 1'b0;
        #1;
        chk_beat("full_w1", 2, 8'hC1);
        next_cycle();
        // Longer than TIMEOUT full window, last asserted but must be ignored
        set_data(2, 8'hC2);
        req_last  = 4'b0100;
        fifo_full = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            check("full16_wen", fifo_w_en, 0);
            check("full16_locked", locked, 1);
            next_cycle();
        end
        fifo_full = 1'b0;
        #1;
        chk_beat("full_w2", 2, 8'hC2);
        next_cycle();
        check("full_done_locked", locked, 0);

        // Producer 0 stalls; counter must clear on beat, then time out after 15 stalls
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        set_data(0, 8'hD0);
        set_data(1, 8'h51);
        #1;
        chk_idle("to_arb");
        next_cycle();
        check("to_grant", grant_id, 0);
        req_valid = 4'b0010;
        req_last  = 4'b0001;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("stall10_locked", locked, 1);
            check("stall10_wen", fifo_w_en, 0);
            check("stall10_ready", req_ready, 4'b0001);
            next_cycle();
        end
        req_valid = 4'b0011;
        req_last  = 4'b0000;
        #1;
        chk_beat("to_w0", 0, 8'hD0);
        next_cycle();
        req_valid = 4'b0010;
        req_last  = 4'b0011;
        #1;
        for (int k = 0; k < 15; k++) begin
            check("stall15_locked", locked, 1);
            check("stall15_wen", fifo_w_en, 0);
            next_cycle();
        end
        chk_idle("to_released");
        next_cycle();
        chk_beat("to_next_p1", 1, 8'h51);
        next_cycle();

        // Reset in the middle of a producer 3 packet
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        set_data(3, 8'hE0);
        set_data(0, 8'hF0);
        #1;
        chk_idle("mr_arb");
        next_cycle();
        chk_beat("mr_p3_w0", 3, 8'hE0);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("mr_rst_wen", fifo_w_en, 0);
        check("mr_rst_ready", req_ready, 0);
        next_cycle();
        rst_n     = 1'b1;
        req_valid = 4'b1001;
        #1;
        chk_idle("mr_after");
        check("mr_after_grant", grant_id, 0);
        next_cycle();
        chk_beat("mr_p0", 0, 8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of producers sharing one sync FIFO write port; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: width of each producer word and of the FIFO write data.
REQ-003 Parameter TIMEOUT, default 15: number of consecutive stalled cycles (locked requester valid low) before forced release; legal range 1..255.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  bit i high: producer i presents a word.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  bit i high: producer i's current word ends its packet.
REQ-009 req_ready  output  NUM_REQ  bit i high: producer i's word is accepted this cycle if valid.
REQ-010 fifo_full  input  1  FIFO full flag.
REQ-011 fifo_w_en  output  1  FIFO write enable.
REQ-012 fifo_wdata  output  DATA_WIDTH  FIFO write data.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the current or most recent grant holder.
REQ-014 locked  output  1  high while in LOCK state.

Function
REQ-015 Two states: IDLE and LOCK.
REQ-016 IDLE: if any req_valid is high, select the first valid index searching upward from rr_ptr with wrap; register it into grant_id and go to LOCK at the next edge; otherwise stay in IDLE.
REQ-017 IDLE: req_ready all zero, fifo_w_en low; the arbitration cycle costs exactly one cycle before the first beat.
REQ-018 LOCK: only req_ready[grant_id] may be high, equal to !fifo_full; all other bits zero.
REQ-019 LOCK: fifo_w_en = req_valid[grant_id] && !fifo_full; fifo_wdata = req_data slice of grant_id; both combinational, same cycle.
REQ-020 A beat is a cycle with fifo_w_en high; a beat with req_last[grant_id] high returns to IDLE and sets rr_ptr = (grant_id+1) mod NUM_REQ.
REQ-021 A full-blocked beat (valid high, fifo_full high) transfers nothing and is not a stall for the timeout.
REQ-022 Stall counter: in LOCK, increments each cycle req_valid[grant_id] is low, clears on any beat and on entry to LOCK; on reaching TIMEOUT, return to IDLE with rr_ptr = grant_id+1 and no write that cycle.
REQ-023 req_last is ignored when valid is low or the FIFO is full.
REQ-024 Packets are never interleaved: a producer's words between grant and last or timeout go to the FIFO contiguously.
REQ-025 fifo_wdata outside LOCK beats: don't-care, but it shall not be X when inputs are known.
REQ-026 No starvation: a continuously valid producer is granted within NUM_REQ-1 intervening packets.

Reset
REQ-027 While rst_n is low, req_ready=0 and fifo_w_en=0 combinationally, regardless of state.
REQ-028 At a clock edge with rst_n low: state=IDLE, grant_id=0, rr_ptr=0, stall counter=0, locked=0.
REQ-029 Reset mid-packet abandons the packet; the first grant after reset uses rr_ptr=0.

Verification
REQ-030 After reset, req_valid=4'b1010, each presenting a 2-word packet -> producer 1 granted first (grant_id=1), 2 beats, one IDLE cycle, then producer 3; FIFO order P1w0,P1w1,P3w0,P3w1.
REQ-031 All 4 producers continuously valid with 1-word packets -> grant sequence 0,1,2,3,0; one write every 2 cycles.
REQ-032 Producer 2 locked, fifo_full held high 5 cycles mid-packet -> fifo_w_en=0 and req_ready[2]=0 for those cycles, no timeout, packet completes after full drops.
REQ-033 Producer 0 locked and drops valid for 15 cycles (TIMEOUT=15) -> locked falls after the 15th stall cycle, rr_ptr=1; producer 1, if valid, is granted next.
REQ-034 rst_n low for 1 cycle during a producer 3 packet -> no write in reset cycle; after reset, requests from producers 0 and 3 -> producer 0 granted.
REQ-035 Random valid/last/full with scoreboard per producer -> no interleaving, no lost or duplicated words, no write while fifo_full high.
